// File: rtl/ysyx_22050243_lsu_ctrl_pkg.sv
// Shared definitions for the MEM-stage load/store controller: funct3 codes,
// FSM states and byte-mask helpers.
package ysyx_22050243_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_DONE      = 2'd3
    } lsu_state_e;

    // Byte-enable pattern for an access of 1/2/4/8 bytes at lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        case (size)
            2'b00:   align_mask = 3'b000;
            2'b01:   align_mask = 3'b001;
            2'b10:   align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22050243_lsu_ctrl_if.sv
// Data-memory bus between the load/store controller (master) and memory (slave).
interface ysyx_22050243_lsu_ctrl_if #(
    parameter int WIDTH = 64
);
    logic             bus_req_valid;
    logic             bus_req_ready;
    logic             bus_req_we;
    logic [WIDTH-1:0] bus_addr;
    logic [7:0]       bus_wstrb;
    logic [WIDTH-1:0] bus_wdata;
    logic             bus_resp_valid;
    logic             bus_resp_ready;
    logic             bus_resp_err;
    logic [WIDTH-1:0] bus_rdata;

    modport master (
        output bus_req_valid, bus_req_we, bus_addr, bus_wstrb, bus_wdata, bus_resp_ready,
        input  bus_req_ready, bus_resp_valid, bus_resp_err, bus_rdata
    );

    modport slave (
        input  bus_req_valid, bus_req_we, bus_addr, bus_wstrb, bus_wdata, bus_resp_ready,
        output bus_req_ready, bus_resp_valid, bus_resp_err, bus_rdata
    );
endinterface

// File: rtl/ysyx_22050243_lsu_ctrl_load_ext.sv
// Load-data aligner: moves the addressed lane down to bit 0, then sign- or
// zero-extends according to the load funct3.
module ysyx_22050243_load_ext
    import ysyx_22050243_lsu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] rdata,
    input  logic [2:0]       offset,
    input  logic [2:0]       funct3,
    output logic [WIDTH-1:0] ext
);
    logic [WIDTH-1:0] shifted_s;

    // Lane shift followed by width-dependent extension.
    always_comb begin
        shifted_s = rdata >> {offset, 3'b000};
        case (funct3)
            F3_LB:   ext = {{(WIDTH-8){shifted_s[7]}},   shifted_s[7:0]};
            F3_LH:   ext = {{(WIDTH-16){shifted_s[15]}}, shifted_s[15:0]};
            F3_LW:   ext = {{(WIDTH-32){shifted_s[31]}}, shifted_s[31:0]};
            F3_LD:   ext = shifted_s;
            F3_LBU:  ext = {{(WIDTH-8){1'b0}},  shifted_s[7:0]};
            F3_LHU:  ext = {{(WIDTH-16){1'b0}}, shifted_s[15:0]};
            F3_LWU:  ext = {{(WIDTH-32){1'b0}}, shifted_s[31:0]};
            default: ext = {WIDTH{1'b0}};
        endcase
    end
endmodule

// File: rtl/ysyx_22050243_lsu_ctrl.sv
// MEM-stage load/store controller: one operation at a time over a valid/ready bus.
// Optional response watchdog enabled by YSYX_22050243_LSU_TIMEOUT_EN.
module ysyx_22050243_lsu_ctrl
    import ysyx_22050243_lsu_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     mem_r,
    input  logic                     mem_w,
    input  logic [2:0]               funct3,
    input  logic [WIDTH-1:0]         addr,
    input  logic [WIDTH-1:0]         wdata,
    ysyx_22050243_lsu_ctrl_if.master bus,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_rdata,
    output logic                     out_err,
    output logic                     stall
);
    if (WIDTH != 64) begin : g_width_chk
        $error("ysyx_22050243_lsu_ctrl supports WIDTH = 64 only");
    end
    if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 255)) begin : g_tmo_chk
        $error("ysyx_22050243_lsu_ctrl TIMEOUT_CYC must fit the 8-bit watchdog");
    end

    lsu_state_e       state_r, state_next_s;
    logic [2:0]       f3_r, off_r;
    logic             we_r;
    logic [2:0]       offset_s, amask_s;
    logic [7:0]       strb_s;
    logic             op_s, illegal_s, misalign_s, bad_s, tmo_s, res_err_s;
    logic [WIDTH-1:0] ext_s, res_rdata_s;

    ysyx_22050243_load_ext #(.WIDTH(WIDTH)) u_load_ext (
        .rdata  (bus.bus_rdata),
        .offset (off_r),
        .funct3 (f3_r),
        .ext    (ext_s)
    );

    // Decode the incoming operation: legality, alignment and byte-lane placement.
    always_comb begin
        offset_s   = addr[2:0];
        amask_s    = align_mask(funct3[1:0]);
        strb_s     = size_mask(funct3[1:0]) << offset_s;
        op_s       = in_valid && (mem_r || mem_w);
        illegal_s  = (mem_r && mem_w) || (mem_r && (funct3 == 3'b111)) ||
                     (mem_w && !(funct3 inside {F3_SB, F3_SH, F3_SW, F3_SD}));
        misalign_s = |(offset_s & amask_s);
        bad_s      = illegal_s || misalign_s;
    end

`ifdef YSYX_22050243_LSU_TIMEOUT_EN
    logic [7:0] tmo_cnt_r;

    // Watchdog: counts response-less cycles spent in WAIT_RESP; zero elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= 8'd0;
        end else if (state_r != ST_WAIT_RESP) begin
            tmo_cnt_r <= 8'd0;
        end else if (!bus.bus_resp_valid) begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
        end
    end

    assign tmo_s = (state_r == ST_WAIT_RESP) && !bus.bus_resp_valid &&
                   (tmo_cnt_r == 8'(TIMEOUT_CYC - 1));
`else
    assign tmo_s = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (op_s) begin
                    state_next_s = bad_s ? ST_DONE : ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.bus_req_ready) state_next_s = ST_WAIT_RESP;
                else                   state_next_s = ST_REQ;
            end
            ST_WAIT_RESP: begin
                if (bus.bus_resp_valid || tmo_s) state_next_s = ST_DONE;
                else                             state_next_s = ST_WAIT_RESP;
            end
            ST_DONE: begin
                if (out_ready) state_next_s = ST_IDLE;
                else           state_next_s = ST_DONE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Result to be latched on entry to DONE; errors and stores return zero data.
    always_comb begin
        res_rdata_s = {WIDTH{1'b0}};
        res_err_s   = 1'b0;
        if (state_r == ST_IDLE) begin
            res_err_s = bad_s;
        end else if (tmo_s || bus.bus_resp_err) begin
            res_err_s = 1'b1;
        end else if (!we_r) begin
            res_rdata_s = ext_s;
        end else begin
            res_rdata_s = {WIDTH{1'b0}};
        end
    end

    // State register and state-decoded handshake outputs, registered from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r            <= ST_IDLE;
            in_ready           <= 1'b1;
            stall              <= 1'b0;
            bus.bus_req_valid  <= 1'b0;
            bus.bus_resp_ready <= 1'b0;
            out_valid          <= 1'b0;
        end else begin
            state_r            <= state_next_s;
            in_ready           <= (state_next_s == ST_IDLE);
            stall              <= (state_next_s != ST_IDLE);
            bus.bus_req_valid  <= (state_next_s == ST_REQ);
            bus.bus_resp_ready <= (state_next_s == ST_WAIT_RESP);
            out_valid          <= (state_next_s == ST_DONE);
        end
    end

    // Operation latch; request fields are only loaded for legal operations and stay put until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_r          <= 3'b000;
            off_r         <= 3'b000;
            we_r          <= 1'b0;
            bus.bus_req_we <= 1'b0;
            bus.bus_addr  <= {WIDTH{1'b0}};
            bus.bus_wstrb <= 8'h00;
            bus.bus_wdata <= {WIDTH{1'b0}};
        end else if ((state_r == ST_IDLE) && op_s) begin
            f3_r  <= funct3;
            off_r <= offset_s;
            we_r  <= mem_w;
            if (!bad_s) begin
                bus.bus_req_we <= mem_w;
                bus.bus_addr   <= {addr[WIDTH-1:3], 3'b000};
                bus.bus_wstrb  <= mem_w ? strb_s : 8'h00;
                bus.bus_wdata  <= wdata << {offset_s, 3'b000};
            end
        end
    end

    // Result registers change only on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_rdata <= {WIDTH{1'b0}};
            out_err   <= 1'b0;
        end else if ((state_next_s == ST_DONE) && (state_r != ST_DONE)) begin
            out_rdata <= res_rdata_s;
            out_err   <= res_err_s;
        end
    end
endmodule
